// File: rtl/cdc_src_arb_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdc_src_arb_clear_ctrl
// Description : Source-domain front end for a clearable two-phase CDC.
//               Arbitrates NUM_REQ packet streams round-robin with a
//               per-packet grant lock, tags each beat with its requester
//               index, and sequences warm clears of the CDC.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_src_arb_clear_ctrl #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 32,
  parameter  int PEND_TIMEOUT = 64,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                          src_clk_i,
  input  logic                          src_rst_ni,
  input  logic                          clear_req_i,
  output logic                          clear_busy_o,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [IDW+DATA_WIDTH-1:0]     cdc_data_o,
  output logic                          cdc_valid_o,
  input  logic                          cdc_ready_i,
  output logic                          cdc_clear_o,
  input  logic                          cdc_clear_pending_i,
  output logic                          abort_o,
  output logic                          timeout_err_o
);

  // Wide enough to hold PEND_TIMEOUT-1 for any legal PEND_TIMEOUT.
  localparam int CNT_W = $clog2(PEND_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_ARB         = 3'd0,
    ST_LOCKED      = 3'd1,
    ST_CLR_ISSUE   = 3'd2,
    ST_CLR_WAIT_HI = 3'd3,
    ST_CLR_WAIT_LO = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic               timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDW-1:0]        arb_grant;
  logic [IDW-1:0]        cand;
  logic [IDW-1:0]        sel;
  logic                  in_xfer;
  logic                  present_valid;
  logic                  block;
  logic                  handshake;
  logic                  sel_last;

  // Pointer advance with explicit wrap so non-power-of-two NUM_REQ works.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Per-requester view of the flattened payload bus.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating-priority search: scan from the farthest offset back to the
  // pointer so the nearest valid requester at or after the pointer wins.
  always_comb begin
    arb_grant = ptr_q;
    cand      = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid_i[cand]) begin
        arb_grant = cand;
      end
    end
  end

  // Output path: present the granted (or locked) requester unless a clear
  // is requested or the CDC is isolated, in which case nothing moves.
  always_comb begin
    in_xfer       = (state_q == ST_ARB) || (state_q == ST_LOCKED);
    sel           = (state_q == ST_LOCKED) ? lock_q : arb_grant;
    present_valid = 1'b0;
    if (state_q == ST_ARB) begin
      present_valid = |req_valid_i;
    end else if (state_q == ST_LOCKED) begin
      present_valid = req_valid_i[lock_q];
    end
    clear_busy_o  = !in_xfer || cdc_clear_pending_i;
    block         = clear_busy_o || clear_req_i;
    cdc_valid_o   = present_valid && !block;
    req_ready_o   = (in_xfer && !block && cdc_ready_i) ? (NUM_REQ'(1) << sel) : '0;
    cdc_data_o    = cdc_valid_o ? {sel, data_arr[sel]} : '0;
    cdc_clear_o   = (state_q == ST_CLR_ISSUE);
    handshake     = cdc_valid_o && cdc_ready_i;
    sel_last      = req_last_i[sel];
    abort_o       = abort_q;
    timeout_err_o = timeout_q;
  end

  // Next-state logic for arbitration, locking and the clear sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_ARB, ST_LOCKED: begin
        if (clear_req_i || cdc_clear_pending_i) begin
          // A local request wins over an external clear already in progress;
          // the wait states absorb a pending that is already high.
          state_d = clear_req_i ? ST_CLR_ISSUE : ST_CLR_WAIT_LO;
          abort_d = (state_q == ST_LOCKED);
        end else if (handshake) begin
          if (sel_last) begin
            ptr_d   = wrap_inc(sel);
            state_d = ST_ARB;
          end else begin
            lock_d  = sel;
            state_d = ST_LOCKED;
          end
        end
      end
      ST_CLR_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_CLR_WAIT_HI;
      end
      ST_CLR_WAIT_HI: begin
        if (cdc_clear_pending_i) begin
          state_d = ST_CLR_WAIT_LO;
        end else if (cnt_q == CNT_W'(PEND_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CLR_WAIT_LO: begin
        if (!cdc_clear_pending_i) begin
          state_d = clear_req_i ? ST_CLR_ISSUE : ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers; asynchronous reset drops any clear sequence at once.
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      lock_q    <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_src_arb_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_src_arb_clear_ctrl
// Description : Self-checking bench for cdc_src_arb_clear_ctrl: directed
//               scenarios with literal expectations, then randomized traffic
//               and clears against a behavioural model, with a small CDC
//               clear-pending emulation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_src_arb_clear_ctrl;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;
  localparam int TO  = 64;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_req;
  logic            clear_busy;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [IDW+DW-1:0] cdc_data;
  logic            cdc_valid;
  logic            cdc_ready;
  logic            cdc_clear;
  logic            cdc_pending;
  logic            abort;
  logic            timeout_err;

  cdc_src_arb_clear_ctrl #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .PEND_TIMEOUT(TO)
  ) dut (
    .src_clk_i          (clk),
    .src_rst_ni         (rst_n),
    .clear_req_i        (clear_req),
    .clear_busy_o       (clear_busy),
    .req_valid_i        (req_valid),
    .req_last_i         (req_last),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .cdc_data_o         (cdc_data),
    .cdc_valid_o        (cdc_valid),
    .cdc_ready_i        (cdc_ready),
    .cdc_clear_o        (cdc_clear),
    .cdc_clear_pending_i(cdc_pending),
    .abort_o            (abort),
    .timeout_err_o      (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus state
  bit          sv [N];
  bit          sl [N];
  logic [DW-1:0] sd [N];
  bit          s_cready, s_clr, s_pend;
  bit          rnd_gen;
  int          rem [N];

  // CDC clear emulation
  bit em_on;
  int em_delay, em_hold;

  // Behavioural model: rr pointer, locked owner (-1 = none), clear phase
  // 0 = moving data, 1 = issuing clear, 2 = waiting for pending, 3 = waiting
  // for pending to drop.
  int m_ptr, m_lock, m_phase, m_age;
  bit m_abort, m_tmo;

  int open_pkt;
  int hs_cnt, clr_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = sv[i];
      req_last[i]            = sl[i];
      req_data[i*DW +: DW]   = sd[i];
    end
    cdc_ready   = s_cready;
    clear_req   = s_clr;
    cdc_pending = s_pend;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_phase = 0; m_age = 0; m_abort = 0; m_tmo = 0;
    em_delay = 0; em_hold = 0; open_pkt = -1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin sv[i] = 0; sl[i] = 0; sd[i] = '0; end
    s_cready = 0; s_clr = 0; s_pend = 0;
    apply();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", cdc_valid, 0);
    chk("rst_data",  cdc_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy",  clear_busy, 0);
    chk("rst_clear", cdc_clear, 0);
    chk("rst_abort", abort, 0);
    chk("rst_tmo",   timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, compare every output against the model, then
  // advance the model by the same edge the DUT sees.
  task automatic step();
    int owner, tag, ab_n;
    bit pres, blk, e_valid, e_busy, e_clear, hs, dut_hs, found;
    logic [N-1:0]  e_ready;
    logic [63:0]   e_data;
    @(negedge clk);
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    if (rnd_gen) begin
      for (int i = 0; i < N; i++) begin
        sv[i] = ($urandom_range(0, 9) < 7);
        sl[i] = (rem[i] == 1);
      end
      s_cready = ($urandom_range(0, 9) < 6);
      if (s_clr) s_clr = ($urandom_range(0, 1) == 1);
      else       s_clr = ($urandom_range(0, 49) == 0);
    end
    if (em_on) begin
      if (em_delay > 0) begin
        em_delay--;
        if (em_delay == 0) em_hold = $urandom_range(1, 5);
      end else if (em_hold == 0 && $urandom_range(0, 199) == 0) begin
        em_hold = $urandom_range(2, 10);
      end
      s_pend = (em_hold > 0);
      if (em_hold > 0) em_hold--;
    end
    apply();
    #1;
    e_busy  = (m_phase != 0) || s_pend;
    e_clear = (m_phase == 1);
    owner   = m_ptr;
    found   = 0;
    if (m_lock >= 0) begin
      owner = m_lock;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && sv[(m_ptr + k) % N]) begin
          owner = (m_ptr + k) % N;
          found = 1;
        end
      end
    end
    pres = (m_lock >= 0) ? sv[owner] : found;
    blk  = e_busy || s_clr;
    e_valid = (m_phase == 0) && pres && !blk;
    e_ready = ((m_phase == 0) && !blk && s_cready) ? (N'(1) << owner) : '0;
    hs      = e_valid && s_cready;
    e_data  = (64'(owner) << DW) | 64'(sd[owner]);
    chk("valid", cdc_valid, e_valid);
    chk("ready", req_ready, e_ready);
    chk("clear", cdc_clear, e_clear);
    chk("busy",  clear_busy, e_busy);
    chk("abort", abort, m_abort);
    chk("tmo",   timeout_err, m_tmo);
    if (e_valid) chk("data", cdc_data, e_data);

    // Stream-level view of accepted beats: packets never interleave.
    dut_hs = cdc_valid && s_cready;
    if (dut_hs) begin
      hs_cnt++;
      tag = int'(cdc_data[DW +: IDW]);
      if (open_pkt >= 0) chk("pkt_interleave", tag, open_pkt);
      open_pkt = sl[tag] ? -1 : tag;
    end
    if (cdc_clear) clr_cnt++;

    ab_n = 0;
    case (m_phase)
      0: begin
        if (s_clr || s_pend) begin
          ab_n     = (m_lock >= 0);
          m_lock   = -1;
          m_phase  = s_clr ? 1 : 3;
          open_pkt = -1;
        end else if (hs) begin
          if (sl[owner]) begin m_ptr = (owner + 1) % N; m_lock = -1; end
          else m_lock = owner;
        end
      end
      1: begin m_phase = 2; m_age = 0; end
      2: begin
        if (s_pend) m_phase = 3;
        else if (m_age == TO - 1) begin m_tmo = 1; m_phase = 0; end
        else m_age++;
      end
      default: if (!s_pend) m_phase = s_clr ? 1 : 0;
    endcase
    m_abort = (ab_n != 0);

    if (rnd_gen) begin
      for (int i = 0; i < N; i++) begin
        if (e_ready[i] && sv[i]) begin
          rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
        end
      end
    end
    if (em_on && e_clear && $urandom_range(0, 9) != 0) em_delay = $urandom_range(1, 3);
  endtask

  task automatic set_all(input bit v, input bit l);
    for (int i = 0; i < N; i++) begin sv[i] = v; sl[i] = l; end
  endtask

  int h0, c0;
  bit did_rst;

  initial begin
    rnd_gen = 0; em_on = 0; hs_cnt = 0; clr_cnt = 0; did_rst = 0;
    model_reset();
    do_reset();

    // Fairness: all requesters, single-beat packets, always ready.
    set_all(1, 1); s_cready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_tag", cdc_data[DW +: IDW], k % N);
    end

    // Lock: req1 3-beat packet with req0/req2 competing, 2-cycle stall.
    set_all(0, 1); sv[0] = 1; sv[1] = 1; sv[2] = 1; sl[1] = 0;
    h0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      s_cready = !(k == 2 || k == 3);
      if (k == 4) sl[1] = 1;
      step();
      chk("lock_tag", cdc_data[DW +: IDW], 1);
      chk("lock_valid", cdc_valid, 1);
    end
    chk("lock_beats", hs_cnt - h0, 3);
    step();
    chk("lock_next", cdc_data[DW +: IDW], 2);

    // Local clear on beat 2 of a 4-beat packet from req3.
    set_all(0, 0); sv[3] = 1; s_cready = 1;
    step();
    chk("lc_beat1", cdc_data[DW +: IDW], 3);
    s_clr = 1; step();
    chk("lc_gate_valid", cdc_valid, 0);
    chk("lc_gate_ready", req_ready, 0);
    s_clr = 0; step();
    chk("lc_abort", abort, 1);
    chk("lc_pulse", cdc_clear, 1);
    chk("lc_pulse_valid", cdc_valid, 0);
    step();
    chk("lc_abort_once", abort, 0);
    chk("lc_pulse_once", cdc_clear, 0);
    s_pend = 1; for (int k = 0; k < 3; k++) step();
    s_pend = 0; step();
    chk("lc_busy_tail", clear_busy, 1);
    set_all(0, 0); step();
    chk("lc_idle", clear_busy, 0);

    // External clear: pending high 10 cycles without a local request.
    set_all(1, 1); s_cready = 1; s_pend = 1;
    h0 = hs_cnt; c0 = clr_cnt;
    for (int k = 0; k < 10; k++) step();
    chk("ext_no_hs", hs_cnt - h0, 0);
    chk("ext_no_clear", clr_cnt - c0, 0);
    s_pend = 0; step();
    chk("ext_tail_valid", cdc_valid, 0);
    step();
    chk("ext_resume_valid", cdc_valid, 1);
    chk("ext_resume_tag", cdc_data[DW +: IDW], 3);

    // Back-to-back: clear request held across the pending-low wait.
    h0 = hs_cnt; c0 = clr_cnt;
    s_clr = 1; step(); step();
    s_pend = 1; step(); step();
    s_pend = 0; step();
    s_clr = 0; step();
    s_pend = 1; step();
    s_pend = 0; step();
    chk("b2b_pulses", clr_cnt - c0, 2);
    chk("b2b_no_hs", hs_cnt - h0, 0);
    step();
    chk("b2b_resume_tag", cdc_data[DW +: IDW], 0);

    // Timeout: clear issued, pending never rises.
    set_all(0, 0); s_cready = 0;
    s_clr = 1; step();
    s_clr = 0;
    for (int k = 0; k < 65; k++) step();
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy", clear_busy, 1);
    step();
    chk("to_set", timeout_err, 1);
    chk("to_released", clear_busy, 0);
    step();
    chk("to_sticky", timeout_err, 1);

    // Randomized traffic with CDC emulation and one mid-sequence reset.
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 4);
    s_clr = 0; s_pend = 0;
    rnd_gen = 1; em_on = 1;
    for (int it = 0; it < 4000; it++) begin
      step();
      if (it > 2000 && !did_rst && m_phase != 0) begin
        do_reset();
        did_rst = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
